// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: frame-granular round-robin arbiter in front of the MAC TX
// AXI-Stream input. Ownership is taken on arbitration and held until the owner's
// tlast handshake, so frames from different sources never interleave.
// Optional stall watchdog compiled in with `define ARB_STALL_TIMEOUT_EN.
module tx_frame_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXIS_DATA_BYTES = 4,
    parameter int GAP_CYCLES      = 0,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rst_n,
    input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*AXIS_DATA_BYTES-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]                 s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                 s_axis_tlast,
    output logic [NUM_PORTS-1:0]                 s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [AXIS_DATA_BYTES-1:0]           m_axis_tkeep,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    output logic                                 m_axis_tuser,
    input  logic                                 m_axis_tready,
    output logic [NUM_PORTS-1:0]                 grant,
    output logic                                 busy,
    output logic [15:0]                          frame_count,
    output logic                                 frame_abort
);

    localparam int unsigned NP       = NUM_PORTS;
    localparam int          IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [3:0]  GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    if (NUM_PORTS < 2 || NUM_PORTS > 4 || GAP_CYCLES < 0 || GAP_CYCLES > 15 ||
        TIMEOUT_CYCLES < 1 || AXIS_DATA_BYTES * 8 != AXIS_DATA_WIDTH) begin : g_param_check
        $error("tx_frame_arbiter: parameter out of range");
    end

`ifdef ARB_STALL_TIMEOUT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_GAP, ST_DROP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_GAP} state_t;
`endif

    localparam state_t ST_AFTER = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_t                     state_q, state_d;
    logic [NUM_PORTS-1:0]       grant_q;
    logic [IDX_W-1:0]           sel_q, rr_ptr_q, arb_idx;
    logic                       arb_found;
    logic [3:0]                 gap_cnt_q;
    logic [15:0]                frame_count_q;
    logic                       frame_done;
    logic                       sel_valid, sel_last;
    logic [AXIS_DATA_WIDTH-1:0] sel_data;
    logic [AXIS_DATA_BYTES-1:0] sel_keep;

    assign sel_valid = s_axis_tvalid[sel_q];
    assign sel_last  = s_axis_tlast[sel_q];
    assign sel_data  = s_axis_tdata[sel_q*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    assign sel_keep  = s_axis_tkeep[sel_q*AXIS_DATA_BYTES +: AXIS_DATA_BYTES];

    // Round-robin search: first valid port starting at rr_ptr, wrapping modulo NUM_PORTS
    always_comb begin
        int unsigned cand;
        cand      = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= NP) cand = cand - NP;
            if (!arb_found && s_axis_tvalid[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_W-1:0];
            end
        end
    end

`ifdef ARB_STALL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] stall_cnt_q;
    logic            abort_active;
    logic            abort_hs;
    logic            drop_done;
    logic            frame_abort_q;

    assign abort_active = (state_q == ST_XFER) && (stall_cnt_q == TO_W'(TIMEOUT_CYCLES));
    assign frame_abort  = frame_abort_q;

    // Consecutive cycles the owner offers nothing; frozen at the limit until the abort beat leaves
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || state_q != ST_XFER) begin
            stall_cnt_q <= '0;
        end else if (!abort_active) begin
            if (!sel_valid) begin
                stall_cnt_q <= stall_cnt_q + TO_W'(1);
            end else if (m_axis_tready) begin
                stall_cnt_q <= '0;
            end
        end
    end

    // One-cycle abort pulse following the abort beat handshake
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) frame_abort_q <= 1'b0;
        else            frame_abort_q <= abort_hs;
    end
`else
    assign frame_abort = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic plus the output mux; everything is zero outside XFER
    always_comb begin
        state_d       = state_q;
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        frame_done    = 1'b0;
`ifdef ARB_STALL_TIMEOUT_EN
        abort_hs      = 1'b0;
        drop_done     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_found) state_d = ST_XFER;
            end
            ST_XFER: begin
`ifdef ARB_STALL_TIMEOUT_EN
                // The synthetic abort beat replaces the owner's stream; source is not acknowledged
                if (abort_active) begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tlast  = 1'b1;
                    m_axis_tuser  = 1'b1;
                    if (m_axis_tready) begin
                        abort_hs = 1'b1;
                        state_d  = ST_DROP;
                    end
                end else begin
`endif
                    m_axis_tdata         = sel_data;
                    m_axis_tkeep         = sel_keep;
                    m_axis_tvalid        = sel_valid;
                    m_axis_tlast         = sel_last;
                    s_axis_tready[sel_q] = m_axis_tready;
                    if (sel_valid && m_axis_tready && sel_last) begin
                        frame_done = 1'b1;
                        state_d    = ST_AFTER;
                    end
`ifdef ARB_STALL_TIMEOUT_EN
                end
`endif
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
            end
`ifdef ARB_STALL_TIMEOUT_EN
            ST_DROP: begin
                s_axis_tready[sel_q] = 1'b1;
                if (sel_valid && sel_last) begin
                    drop_done = 1'b1;
                    state_d   = ST_AFTER;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant/pointer registers, gap timer and completed-frame counter
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            grant_q       <= '0;
            sel_q         <= '0;
            rr_ptr_q      <= '0;
            gap_cnt_q     <= '0;
            frame_count_q <= '0;
        end else begin
            if (state_q == ST_IDLE && arb_found) begin
                grant_q  <= NUM_PORTS'(1) << arb_idx;
                sel_q    <= arb_idx;
                rr_ptr_q <= (32'(arb_idx) == NP - 1) ? '0 : arb_idx + IDX_W'(1);
            end
            if (frame_done) begin
                frame_count_q <= frame_count_q + 16'd1;
                grant_q       <= '0;
            end
`ifdef ARB_STALL_TIMEOUT_EN
            if (drop_done) grant_q <= '0;
`endif
            gap_cnt_q <= (state_q == ST_GAP) ? gap_cnt_q + 4'd1 : 4'd0;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_count = frame_count_q;

endmodule
